obi_host_mailbox: RTL and testbench

// OBI responder (target) on the gr-heep bus: the core-side counterpart of the host->OBI initiator bridge.

---
 rtl/obi_host_mailbox_pkg.sv | 36 +++
 rtl/mailbox_sync_fifo.sv | 60 ++++++
 rtl/obi_host_mailbox.sv | 130 +++++++++++++
 tb/tb_obi_host_mailbox.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/obi_host_mailbox_pkg.sv
// Shared definitions for the host<->core OBI mailbox: register offsets,
// STATUS/CTRL bit positions and the STATUS word layout.
package obi_host_mailbox_pkg;

    typedef enum logic [1:0] {
        REG_DATA_TX = 2'd0,
        REG_DATA_RX = 2'd1,
        REG_STATUS  = 2'd2,
        REG_CTRL    = 2'd3
    } reg_off_e;

    localparam int ST_H2C_EMPTY = 0;
    localparam int ST_H2C_FULL  = 1;
    localparam int ST_C2H_EMPTY = 2;
    localparam int ST_C2H_FULL  = 3;
    localparam int ST_OVF       = 4;
    localparam int ST_UDF       = 5;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_CLEAR   = 1;

    // STATUS word, MSB first
    typedef struct packed {
        logic [7:0] rsvd_hi;
        logic [7:0] c2h_cnt;
        logic [7:0] h2c_cnt;
        logic [1:0] rsvd_lo;
        logic       udf;
        logic       ovf;
        logic       c2h_full;
        logic       c2h_empty;
        logic       h2c_full;
        logic       h2c_empty;
    } status_t;

endpackage

// File: rtl/mailbox_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Push into a full FIFO and pop from an empty one are ignored; clr_i empties
// the FIFO and overrides any push/pop in the same cycle.
module mailbox_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // full/empty come from the registered count, so a pop never frees room
    // for a push in the same cycle
    assign full_o  = (r_count == (AW+1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign rdata_o = r_mem[r_rptr];
    assign w_push  = push_i & ~full_o & ~clr_i;
    assign w_pop   = pop_i & ~empty_o & ~clr_i;

    // storage array, no reset needed
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= wdata_i;
    end

    // pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/obi_host_mailbox.sv
// OBI responder exposing a two-FIFO mailbox between the core and the
// external host, plus STATUS/CTRL registers and a level interrupt.
module obi_host_mailbox
    import obi_host_mailbox_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic        host_wvalid_i,
    input  logic [31:0] host_wdata_i,
    output logic        host_wready_o,
    output logic        host_rvalid_o,
    output logic [31:0] host_rdata_o,
    input  logic        host_rready_i,
    output logic        irq_o
);

    reg_off_e    w_off;
    logic        w_wr, w_rd, w_ctrl_wr, w_clear, w_c2h_push, w_h2c_pop;
    logic        w_h2c_full, w_h2c_empty, w_c2h_full, w_c2h_empty;
    logic [31:0] w_h2c_rdata, w_rdata;
    logic [CNT_W-1:0] w_h2c_cnt, w_c2h_cnt;
    status_t     w_status;
    logic        w_unused;

    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_ovf, r_udf, r_irq_en, r_irq;

    assign w_off      = reg_off_e'(addr_i[3:2]);
    assign w_wr       = req_i & we_i;
    assign w_rd       = req_i & ~we_i;
    assign w_ctrl_wr  = w_wr & (w_off == REG_CTRL) & be_i[0];
    assign w_clear    = w_ctrl_wr & wdata_i[CTRL_CLEAR];
    assign w_c2h_push = w_wr & (w_off == REG_DATA_TX);
    assign w_h2c_pop  = w_rd & (w_off == REG_DATA_RX);
    assign w_unused   = ^{addr_i[31:4], addr_i[1:0], be_i[3:1], wdata_i[31:2]};

    mailbox_sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_h2c (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(w_clear),
        .push_i(host_wvalid_i), .wdata_i(host_wdata_i),
        .pop_i(w_h2c_pop), .rdata_o(w_h2c_rdata),
        .full_o(w_h2c_full), .empty_o(w_h2c_empty), .count_o(w_h2c_cnt)
    );

    mailbox_sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_c2h (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(w_clear),
        .push_i(w_c2h_push), .wdata_i(wdata_i),
        .pop_i(host_rready_i), .rdata_o(host_rdata_o),
        .full_o(w_c2h_full), .empty_o(w_c2h_empty), .count_o(w_c2h_cnt)
    );

    assign gnt_o         = req_i;
    assign rvalid_o      = r_rvalid;
    assign rdata_o       = r_rdata;
    assign host_wready_o = ~w_h2c_full;
    assign host_rvalid_o = ~w_c2h_empty;
    assign irq_o         = r_irq;

    // assemble STATUS from FIFO flags, counts and sticky bits
    always_comb begin
        w_status           = '0;
        w_status.h2c_empty = w_h2c_empty;
        w_status.h2c_full  = w_h2c_full;
        w_status.c2h_empty = w_c2h_empty;
        w_status.c2h_full  = w_c2h_full;
        w_status.ovf       = r_ovf;
        w_status.udf       = r_udf;
        w_status.h2c_cnt   = 8'(w_h2c_cnt);
        w_status.c2h_cnt   = 8'(w_c2h_cnt);
    end

    // read mux; writes and idle cycles return zero
    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_off)
                REG_DATA_TX: w_rdata = '0;
                REG_DATA_RX: w_rdata = w_h2c_empty ? 32'h0 : w_h2c_rdata;
                REG_STATUS:  w_rdata = w_status;
                REG_CTRL:    w_rdata = {31'h0, r_irq_en};
                default:     w_rdata = '0;
            endcase
        end
    end

    // one-cycle OBI response: rvalid follows every granted request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= req_i;
            r_rdata  <= w_rdata;
        end
    end

    // sticky overflow/underflow, cleared by reset or CTRL.clear
    always_ff @(posedge clk_i) begin
        if (rst_i || w_clear) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_c2h_push && w_c2h_full)  r_ovf <= 1'b1;
            if (w_h2c_pop  && w_h2c_empty) r_udf <= 1'b1;
        end
    end

    // CTRL.irq_en register and registered level interrupt
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_en <= wdata_i[CTRL_IRQ_EN];
            r_irq <= r_irq_en & ~w_h2c_empty;
        end
    end

endmodule

// File: tb/tb_obi_host_mailbox.sv
// Self-checking bench for obi_host_mailbox: table-driven OBI vectors with a
// response scoreboard, plus hand-written multi-cycle corner cases.
module tb_obi_host_mailbox;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        gnt, rvalid;
    logic        h_wv, h_wr, h_rv, h_rr, irq;
    logic [31:0] h_wd, h_rd;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic        we;
        logic [1:0]  off;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t t1[4];
    vec_t t3[5];

    obi_host_mailbox #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .host_wvalid_i(h_wv), .host_wdata_i(h_wd),
        .host_wready_o(h_wr), .host_rvalid_o(h_rv), .host_rdata_o(h_rd),
        .host_rready_i(h_rr), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // one OBI transaction; expected rdata goes through the scoreboard
    task automatic obi(input logic w, input logic [1:0] off, input logic [31:0] d,
                       input logic [31:0] e);
        logic [31:0] x;
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = {28'h0, off, 2'b00}; be = 4'hF; wdata = d;
        sb.push_back(e);
        #1 chk("gnt", 32'(gnt), 32'd1);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        @(negedge clk);
        chk("rvalid", 32'(rvalid), 32'd1);
        x = sb.pop_front();
        chk("rdata", rdata, x);
    endtask

    task automatic idle_chk();
        @(negedge clk);
        chk("rvalid_idle", 32'(rvalid), 32'd0);
        chk("rdata_idle", rdata, 32'd0);
    endtask

    task automatic host_push(input logic [31:0] d);
        @(posedge clk); #1;
        h_wv = 1'b1; h_wd = d;
        @(posedge clk); #1;
        h_wv = 1'b0;
    endtask

    task automatic host_pop(input logic [31:0] e);
        @(posedge clk); #1;
        chk("host_rvalid", 32'(h_rv), 32'd1);
        chk("host_rdata", h_rd, e);
        h_rr = 1'b1;
        @(posedge clk); #1;
        h_rr = 1'b0;
    endtask

    initial begin
        logic [31:0] x;
        t1[0] = '{1'b0, 2'd1, 32'h0, 32'hA5A5_0001};
        t1[1] = '{1'b0, 2'd1, 32'h0, 32'hA5A5_0002};
        t1[2] = '{1'b0, 2'd1, 32'h0, 32'hA5A5_0003};
        t1[3] = '{1'b0, 2'd2, 32'h0, 32'h0000_0005};
        t3[0] = '{1'b0, 2'd1, 32'h0, 32'h0000_0000};
        t3[1] = '{1'b0, 2'd2, 32'h0, 32'h0000_0035};
        t3[2] = '{1'b1, 2'd3, 32'h2, 32'h0000_0000};
        t3[3] = '{1'b0, 2'd2, 32'h0, 32'h0000_0005};
        t3[4] = '{1'b0, 2'd3, 32'h0, 32'h0000_0000};

        rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
        h_wv = 1'b0; h_wd = '0; h_rr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_wready", 32'(h_wr), 32'd1);
        chk("rst_hrvalid", 32'(h_rv), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);

        // 1: host pushes three words, core drains them in order
        for (int i = 1; i <= 3; i++) host_push(32'hA5A5_0000 + 32'(i));
        for (int i = 0; i < 4; i++) obi(t1[i].we, t1[i].off, t1[i].wd, t1[i].exp);
        idle_chk();

        // 2: C2H overflow on the ninth write; host sees the first eight
        for (int i = 0; i < 9; i++) obi(1'b1, 2'd0, 32'h1000_0000 + 32'(i), 32'h0);
        chk("c2h_hrvalid", 32'(h_rv), 32'd1);
        obi(1'b0, 2'd2, 32'h0, 32'h0008_0019);
        for (int i = 0; i < 8; i++) host_pop(32'h1000_0000 + 32'(i));
        chk("c2h_drained", 32'(h_rv), 32'd0);

        // 3: underflow, then clear via CTRL
        for (int i = 0; i < 5; i++) obi(t3[i].we, t3[i].off, t3[i].wd, t3[i].exp);

        // 4: interrupt timing
        obi(1'b1, 2'd3, 32'h1, 32'h0);
        obi(1'b0, 2'd3, 32'h0, 32'h1);
        @(posedge clk); #1;
        h_wv = 1'b1; h_wd = 32'hC0DE_0001;
        @(posedge clk); #1;
        h_wv = 1'b0;
        @(negedge clk);
        chk("irq_lat1", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_lat2", 32'(irq), 32'd1);
        obi(1'b0, 2'd1, 32'h0, 32'hC0DE_0001);
        chk("irq_during_rvalid", 32'(irq), 32'd1);
        @(negedge clk);
        chk("irq_after_pop", 32'(irq), 32'd0);

        // 5a: H2C full, host push and core pop together
        for (int i = 0; i < DEPTH; i++) host_push(32'h2000_0000 + 32'(i));
        @(posedge clk); #1;
        chk("h2c_full_wready", 32'(h_wr), 32'd0);
        h_wv = 1'b1; h_wd = 32'hBAD0_BAD0;
        req = 1'b1; we = 1'b0; addr = 32'h4; be = 4'hF;
        sb.push_back(32'h2000_0000);
        @(posedge clk); #1;
        h_wv = 1'b0; req = 1'b0; addr = '0; be = '0;
        @(negedge clk);
        chk("simul_rvalid", 32'(rvalid), 32'd1);
        x = sb.pop_front();
        chk("simul_rdata", rdata, x);
        obi(1'b0, 2'd2, 32'h0, 32'h0000_0704);
        chk("h2c_7_wready", 32'(h_wr), 32'd1);
        for (int i = 1; i < DEPTH; i++) obi(1'b0, 2'd1, 32'h0, 32'h2000_0000 + 32'(i));
        obi(1'b0, 2'd2, 32'h0, 32'h0000_0005);

        // 5b: C2H at count 3, core push and host pop together
        for (int i = 0; i < 3; i++) obi(1'b1, 2'd0, 32'h3000_0000 + 32'(i), 32'h0);
        @(posedge clk); #1;
        chk("c2h_head", h_rd, 32'h3000_0000);
        h_rr = 1'b1;
        req = 1'b1; we = 1'b1; addr = 32'h0; be = 4'hF; wdata = 32'h3000_0003;
        sb.push_back(32'h0);
        @(posedge clk); #1;
        h_rr = 1'b0; req = 1'b0; we = 1'b0; be = '0; wdata = '0;
        @(negedge clk);
        chk("simul2_rvalid", 32'(rvalid), 32'd1);
        x = sb.pop_front();
        chk("simul2_rdata", rdata, x);
        obi(1'b0, 2'd2, 32'h0, 32'h0003_0001);
        for (int i = 1; i <= 3; i++) host_pop(32'h3000_0000 + 32'(i));
        chk("c2h_empty_end", 32'(h_rv), 32'd0);

        // 6: reset while a response is pending
        host_push(32'h4000_0000);
        host_push(32'h4000_0001);
        @(negedge clk);
        chk("irq_pre_rst", 32'(irq), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h8; be = 4'hF;
        #1 chk("rst_gnt_req", 32'(gnt), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0; addr = '0; be = '0;
        @(negedge clk);
        chk("rst2_rvalid", 32'(rvalid), 32'd0);
        chk("rst2_rdata", rdata, 32'd0);
        chk("rst2_wready", 32'(h_wr), 32'd1);
        chk("rst2_hrvalid", 32'(h_rv), 32'd0);
        chk("rst2_irq", 32'(irq), 32'd0);
        obi(1'b0, 2'd2, 32'h0, 32'h0000_0005);
        obi(1'b0, 2'd3, 32'h0, 32'h0000_0000);
        idle_chk();
        chk("sb_leftover", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
